dma_channel_arbiter: RTL and testbench
======================================

# dma_channel_arbiter

Parametrised N-channel arbiter for the MAC DMA path. It grants exclusive access to the shared read/write controller to one of NUM_CH requesters (RX list processor, TX status updater, TX list processor, plus future channels). Each arbitration uses either fixed priority or round-robin. An optional per-grant cycle budget lets the block revoke a long-held grant when others are waiting. It sits between the list processors/status updaters and the read/write controller, in the macPIClk domain.

## Interface
- NUM_CH, 4, number of requesting channels (2..16); channel 0 is highest priority in fixed mode
- CNT_WIDTH, 8, width of the grant-duration counter and budget input
- ID_WIDTH, $clog2(NUM_CH), width of grantId
- macPIClk  in  1  platform clock
- macPIClkHardRst_n  in  1  reset, asynchronous, active-low
- macPIClkSoftRst_n  in  1  synchronous soft reset, active-low; returns all state to reset values
- rdWrCtlrIdle  in  1  read/write controller idle; new grants and preemption only occur while high
- chReq  in  NUM_CH  per-channel request, level, held until transfer complete
- rrMode  in  1  1 = round-robin, 0 = fixed priority; sampled only in IDLE
- maxGrantCycles  in  CNT_WIDTH  grant budget in cycles; 0 = unlimited (no preemption)
- chGrant  out  NUM_CH  one-hot grant, registered
- grantValid  out  1  OR of chGrant
- grantId  out  ID_WIDTH  index of granted channel; holds last value when no grant
- preemptPulse  out  1  one-cycle pulse when a grant is revoked by budget expiry

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if rdWrCtlrIdle=1 and any eligible chReq bit is set, select a winner and go to GRANT; otherwise stay in IDLE.
- Fixed mode: the winner is the lowest-index eligible request.
- Round-robin mode: the search starts at lastId+1 and wraps modulo NUM_CH. lastId resets to NUM_CH-1, so channel 0 wins first. lastId updates to the winner on every grant, in both modes.
- Eligible = chReq with the preemptMask bit cleared. preemptMask holds only the channel just preempted and is cleared after the next IDLE cycle, whether or not that cycle grants. If the preempted channel is the only requester, it is regranted on the following arbitration.
- GRANT: if chReq[grantId]=0, go to IDLE.
- Else if maxGrantCycles≠0, grantCnt ≥ maxGrantCycles, another chReq bit is set and rdWrCtlrIdle=1: preempt. Go to IDLE, pulse preemptPulse, and set preemptMask to that channel.
- Otherwise stay in GRANT.
- grantCnt: loads 1 on entry to GRANT, increments each GRANT cycle, saturates at all ones, and clears in IDLE.
- A request deasserting in the same cycle the budget expires is a normal release (no pulse).
- Illegal state encodings go to IDLE.
- Reset (hard or soft, including mid-grant): state IDLE, chGrant=0, grantValid=0, grantId=0, preemptPulse=0, grantCnt=0, lastId=NUM_CH-1, preemptMask=0.

## Timing
- Request-to-grant latency: the request is sampled in IDLE at cycle t with rdWrCtlrIdle=1; chGrant is high from t+1.
- Release: chReq low at cycle t gives chGrant low at t+1.
- At least one IDLE cycle always separates consecutive grants. Grants never overlap, and no output is combinational from inputs.
- With budget B, a preempt decision is possible from the B-th grant cycle onward. chGrant drops the cycle after that decision, and preemptPulse is high in that same cycle.
- A change to rrMode or maxGrantCycles during GRANT takes effect at the next IDLE evaluation (budget) or arbitration (mode).

## Test plan
- Fixed mode, NUM_CH=4, chReq=4'b0110 held, rdWrCtlrIdle=1 -> chGrant=0010 one cycle later. Drop chReq[1] -> one IDLE cycle, then chGrant=0100.
- Round-robin, all four requests held, each released after 3 grant cycles and re-raised -> grant order 0,1,2,3,0; grantId matches the order; one IDLE gap between grants.
- Round-robin, chReq=1111 held continuously, maxGrantCycles=5 -> each grant lasts exactly 5 cycles, preemptPulse after each, order 0,1,2,3,0.
- Fixed mode, maxGrantCycles=4, chReq=0011 held -> ch0 granted 4 cycles, preempted, ch1 granted 4 cycles, preempted, ch0 granted again. Repeat with only ch0 requesting -> no preemption.
- rdWrCtlrIdle=0 with chReq=0001 -> no grant; raise rdWrCtlrIdle -> grant next cycle. In GRANT with the budget expired and rdWrCtlrIdle=0 -> grant held until idle returns.
- Soft reset pulse mid-grant on ch2 -> all outputs 0 next cycle, lastId back to 3, so ch0 wins the next round-robin arbitration. Repeat with hard reset asserted asynchronously.

Source files
------------

// File: rtl/dma_channel_arbiter_if.sv
// Request/grant bundle between the DMA requesters and the channel arbiter.
// Handshake: a requester holds chReq[i] high (level) until its transfer is
// complete; it owns the read/write controller only while chGrant[i] is high.
// It must drop chReq[i] to give the controller back, and it may lose the grant
// early when preemptPulse fires.
interface dma_channel_arbiter_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int ID_WIDTH  = $clog2(NUM_CH)
);
    logic                 rdWrCtlrIdle;
    logic [NUM_CH-1:0]    chReq;
    logic                 rrMode;
    logic [CNT_WIDTH-1:0] maxGrantCycles;
    logic [NUM_CH-1:0]    chGrant;
    logic                 grantValid;
    logic [ID_WIDTH-1:0]  grantId;
    logic                 preemptPulse;

    // Requester / environment side.
    modport master (
        output rdWrCtlrIdle, chReq, rrMode, maxGrantCycles,
        input  chGrant, grantValid, grantId, preemptPulse
    );

    // Arbiter side.
    modport slave (
        input  rdWrCtlrIdle, chReq, rrMode, maxGrantCycles,
        output chGrant, grantValid, grantId, preemptPulse
    );
endinterface

// File: rtl/dma_channel_arbiter.sv
// N-channel arbiter that hands the shared read/write controller to one DMA
// requester at a time. Winner selection is fixed priority (channel 0 first)
// or round-robin starting after the last winner. A non-zero grant budget
// lets a long-held grant be revoked when another channel is waiting; the
// revoked channel is skipped for exactly one arbitration.
module dma_channel_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int ID_WIDTH  = $clog2(NUM_CH)
) (
    input  logic                      macPIClk,
    input  logic                      macPIClkHardRst_n,
    input  logic                      macPIClkSoftRst_n,
    dma_channel_arbiter_if.slave      arb,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    localparam logic [ID_WIDTH-1:0] LAST_ID_RST = ID_WIDTH'(NUM_CH - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] grant_cnt;
    logic [ID_WIDTH-1:0]  last_id;
    logic [NUM_CH-1:0]    preempt_mask;

    logic [NUM_CH-1:0]    eligible;
    logic [NUM_CH-1:0]    others;
    logic [ID_WIDTH-1:0]  win_id;
    logic                 win_found;
    logic                 hold_req;
    logic                 budget_hit;

    assign state_dbg = state;

    // Requests that may take part in this arbitration, plus grant-side status.
    always_comb begin
        eligible   = arb.chReq & ~preempt_mask;
        others     = arb.chReq & ~(NUM_CH'(1) << arb.grantId);
        hold_req   = arb.chReq[arb.grantId];
        budget_hit = (arb.maxGrantCycles != '0) && (grant_cnt >= arb.maxGrantCycles);
    end

    // Winner search: index order in fixed mode, rotated past last_id in round-robin.
    always_comb begin : win_search
        logic [ID_WIDTH-1:0] cand;
        cand      = '0;
        win_id    = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (arb.rrMode) begin
                cand = ID_WIDTH'((int'(last_id) + 1 + k) % NUM_CH);
            end else begin
                cand = ID_WIDTH'(k);
            end
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge macPIClk or negedge macPIClkHardRst_n) begin
        if (!macPIClkHardRst_n) begin
            state            <= IDLE;
            arb.chGrant      <= '0;
            arb.grantValid   <= 1'b0;
            arb.grantId      <= '0;
            arb.preemptPulse <= 1'b0;
            grant_cnt        <= '0;
            last_id          <= LAST_ID_RST;
            preempt_mask     <= '0;
        end else if (!macPIClkSoftRst_n) begin
            state            <= IDLE;
            arb.chGrant      <= '0;
            arb.grantValid   <= 1'b0;
            arb.grantId      <= '0;
            arb.preemptPulse <= 1'b0;
            grant_cnt        <= '0;
            last_id          <= LAST_ID_RST;
            preempt_mask     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    arb.preemptPulse <= 1'b0;
                    grant_cnt        <= '0;
                    // The mask only ever shields one arbitration.
                    preempt_mask     <= '0;
                    if (arb.rdWrCtlrIdle && win_found) begin
                        state          <= GRANT;
                        arb.chGrant    <= NUM_CH'(1) << win_id;
                        arb.grantValid <= 1'b1;
                        arb.grantId    <= win_id;
                        last_id        <= win_id;
                        grant_cnt      <= CNT_WIDTH'(1);
                    end
                end
                GRANT: begin
                    arb.preemptPulse <= 1'b0;
                    if (!hold_req) begin
                        // Normal release wins over a budget expiry in the same cycle.
                        state          <= IDLE;
                        arb.chGrant    <= '0;
                        arb.grantValid <= 1'b0;
                        grant_cnt      <= '0;
                    end else if (budget_hit && (|others) && arb.rdWrCtlrIdle) begin
                        state            <= IDLE;
                        arb.chGrant      <= '0;
                        arb.grantValid   <= 1'b0;
                        arb.preemptPulse <= 1'b1;
                        preempt_mask     <= arb.chGrant;
                        grant_cnt        <= '0;
                    end else if (grant_cnt != '1) begin
                        grant_cnt <= grant_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state            <= IDLE;
                    arb.chGrant      <= '0;
                    arb.grantValid   <= 1'b0;
                    arb.preemptPulse <= 1'b0;
                    grant_cnt        <= '0;
                    preempt_mask     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed scenarios followed by random traffic.
// A reference model turns each cycle's inputs into completed-grant records
// (start cycle, length, preempted flag, channel); a monitor rebuilds the same
// records from the DUT outputs and compares them against the expected queue.
module tb_dma_channel_arbiter;

    localparam int N      = 4;
    localparam int CW     = 8;
    localparam int REC_W  = 33;

    logic       clk;
    logic       hard_n;
    logic       soft_n;
    logic [1:0] state_dbg;

    dma_channel_arbiter_if #(.NUM_CH(N), .CNT_WIDTH(CW)) bus ();

    dma_channel_arbiter #(.NUM_CH(N), .CNT_WIDTH(CW)) dut (
        .macPIClk          (clk),
        .macPIClkHardRst_n (hard_n),
        .macPIClkSoftRst_n (soft_n),
        .arb               (bus.slave),
        .state_dbg         (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [REC_W-1:0] exp_q[$];

    // Reference model state, kept as plain integers.
    int m_holder = -1;
    int m_start  = 0;
    int m_last   = N - 1;
    int m_masked = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_rec(input int s, input int len, input logic pre, input int id);
        exp_q.push_back({16'(s), 12'(len), pre, 4'(id)});
    endtask

    // What the arbiter should do at clock edge e given the inputs it samples there.
    task automatic model_edge(input int e, input logic [N-1:0] req, input logic idle,
                              input logic rr, input int maxb, input logic rst);
        int win;
        int c;
        int held;
        if (rst) begin
            if (m_holder >= 0) push_rec(m_start, e - m_start, 1'b0, m_holder);
            m_holder = -1;
            m_last   = N - 1;
            m_masked = -1;
        end else if (m_holder < 0) begin
            win = -1;
            if (idle) begin
                for (int k = 0; k < N; k++) begin
                    c = rr ? (m_last + 1 + k) % N : k;
                    if (win < 0 && req[c] && c != m_masked) win = c;
                end
            end
            m_masked = -1;
            if (win >= 0) begin
                m_holder = win;
                m_start  = e;
                m_last   = win;
            end
        end else begin
            held = e - m_start;
            if (held > 255) held = 255;
            if (!req[m_holder]) begin
                push_rec(m_start, e - m_start, 1'b0, m_holder);
                m_holder = -1;
            end else if (maxb != 0 && held >= maxb && (req & ~(4'b0001 << m_holder)) != 0 && idle) begin
                push_rec(m_start, e - m_start, 1'b1, m_holder);
                m_masked = m_holder;
                m_holder = -1;
            end
        end
    endtask

    // Driver: apply one cycle of inputs at the falling edge.
    task automatic step(input logic [N-1:0] req, input logic idle, input logic rr,
                        input int maxb, input logic sft);
        @(negedge clk);
        bus.chReq          = req;
        bus.rdWrCtlrIdle   = idle;
        bus.rrMode         = rr;
        bus.maxGrantCycles = CW'(maxb);
        soft_n             = sft;
        model_edge(cyc + 1, req, idle, rr, maxb, !sft);
    endtask

    // Driver: assert hard reset between edges, hold it over one edge, release between edges.
    task automatic hard_reset_step(input logic [N-1:0] req);
        @(negedge clk);
        bus.chReq        = req;
        bus.rdWrCtlrIdle = 1'b1;
        bus.rrMode       = 1'b1;
        soft_n           = 1'b1;
        #2 hard_n = 1'b0;
        #1;
        check("async_rst_grant", 64'(bus.chGrant), 64'(0));
        check("async_rst_valid", 64'(bus.grantValid), 64'(0));
        check("async_rst_id", 64'(bus.grantId), 64'(0));
        model_edge(cyc + 1, req, 1'b1, 1'b1, 0, 1'b1);
        @(posedge clk);
        #2 hard_n = 1'b1;
    endtask

    function automatic int held_now();
        return (m_holder >= 0) ? (cyc + 1 - m_start) : 0;
    endfunction

    // Monitor / scoreboard: rebuild grant records from the DUT and compare.
    initial begin : monitor
        logic [N-1:0]     prev;
        logic [N-1:0]     cur;
        logic [REC_W-1:0] act;
        logic [REC_W-1:0] exp;
        int               cur_start;
        int               cur_id;
        int               id;
        prev      = '0;
        cur_start = 0;
        cur_id    = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            cur = bus.chGrant;
            check("grant_valid", 64'(bus.grantValid), 64'(cur != 0));
            if (cur != 0) begin
                id = 0;
                for (int i = 0; i < N; i++) if (cur[i]) id = i;
                check("grant_onehot", 64'($onehot(cur)), 64'(1));
                check("grant_id", 64'(bus.grantId), 64'(id));
                if (prev == 0) begin
                    cur_start = cyc;
                    cur_id    = id;
                end else begin
                    check("grant_no_overlap", 64'(cur), 64'(prev));
                end
            end
            if (prev != 0 && cur == 0) begin
                act = {16'(cur_start), 12'(cyc - cur_start), bus.preemptPulse, 4'(cur_id)};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_rec at cycle %0d: got %0h, expected none", cyc, act);
                end else begin
                    exp = exp_q.pop_front();
                    check("grant_rec", 64'(act), 64'(exp));
                end
            end else begin
                check("no_pulse", 64'(bus.preemptPulse), 64'(0));
            end
            prev = cur;
        end
    end

    // Stimulus
    initial begin : stimulus
        logic [N-1:0] rq;
        logic         rr;
        logic         idle;
        int           maxb;
        int           budgets[5];
        budgets = '{0, 1, 2, 3, 7};

        hard_n             = 1'b0;
        soft_n             = 1'b1;
        bus.chReq          = '0;
        bus.rdWrCtlrIdle   = 1'b0;
        bus.rrMode         = 1'b0;
        bus.maxGrantCycles = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_grant", 64'(bus.chGrant), 64'(0));
        check("rst_valid", 64'(bus.grantValid), 64'(0));
        check("rst_id", 64'(bus.grantId), 64'(0));
        check("rst_pulse", 64'(bus.preemptPulse), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(0));
        hard_n = 1'b1;

        // Fixed priority, then drop the winner.
        repeat (4) step(4'b0110, 1'b1, 1'b0, 0, 1'b1);
        repeat (4) step(4'b0100, 1'b1, 1'b0, 0, 1'b1);
        repeat (2) step(4'b0000, 1'b1, 1'b0, 0, 1'b1);

        // Round-robin, each holder releases after three grant cycles.
        step(4'b0000, 1'b1, 1'b1, 0, 1'b0);
        repeat (22) begin
            rq = 4'b1111;
            if (held_now() >= 3) rq[m_holder] = 1'b0;
            step(rq, 1'b1, 1'b1, 0, 1'b1);
        end

        // Round-robin, all held, budget 5.
        step(4'b0000, 1'b1, 1'b1, 0, 1'b0);
        repeat (32) step(4'b1111, 1'b1, 1'b1, 5, 1'b1);

        // Fixed, budget 4, two requesters, then a lone requester.
        step(4'b0000, 1'b1, 1'b0, 0, 1'b0);
        repeat (20) step(4'b0011, 1'b1, 1'b0, 4, 1'b1);
        repeat (2) step(4'b0000, 1'b1, 1'b0, 4, 1'b1);
        repeat (12) step(4'b0001, 1'b1, 1'b0, 4, 1'b1);
        repeat (2) step(4'b0000, 1'b1, 1'b0, 4, 1'b1);

        // Controller busy blocks grants and preemption.
        repeat (3) step(4'b0001, 1'b0, 1'b0, 2, 1'b1);
        repeat (2) step(4'b0001, 1'b1, 1'b0, 2, 1'b1);
        repeat (6) step(4'b0011, 1'b0, 1'b0, 2, 1'b1);
        repeat (3) step(4'b0011, 1'b1, 1'b0, 2, 1'b1);
        repeat (3) step(4'b0000, 1'b1, 1'b0, 0, 1'b1);

        // Soft reset mid-grant on channel 2, then round-robin restarts at channel 0.
        step(4'b0000, 1'b1, 1'b1, 0, 1'b0);
        step(4'b0001, 1'b1, 1'b1, 0, 1'b1);
        step(4'b0000, 1'b1, 1'b1, 0, 1'b1);
        step(4'b0000, 1'b1, 1'b1, 0, 1'b1);
        repeat (4) step(4'b0100, 1'b1, 1'b1, 0, 1'b1);
        step(4'b0100, 1'b1, 1'b1, 0, 1'b0);
        repeat (3) step(4'b1111, 1'b1, 1'b1, 0, 1'b1);
        repeat (2) step(4'b0000, 1'b1, 1'b1, 0, 1'b1);

        // Same with an asynchronous hard reset.
        step(4'b0001, 1'b1, 1'b1, 0, 1'b1);
        step(4'b0000, 1'b1, 1'b1, 0, 1'b1);
        step(4'b0000, 1'b1, 1'b1, 0, 1'b1);
        repeat (4) step(4'b0100, 1'b1, 1'b1, 0, 1'b1);
        hard_reset_step(4'b0100);
        repeat (3) step(4'b1111, 1'b1, 1'b1, 0, 1'b1);
        repeat (2) step(4'b0000, 1'b1, 1'b1, 0, 1'b1);

        // Random traffic with occasional mode/budget changes and soft resets.
        rq   = '0;
        rr   = 1'b0;
        maxb = 0;
        repeat (3000) begin
            if ($urandom_range(0, 49) == 0) rr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) maxb = budgets[$urandom_range(0, 4)];
            for (int c = 0; c < N; c++) begin
                if (rq[c]) begin
                    if ($urandom_range(0, (m_holder == c) ? 7 : 29) == 0) rq[c] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) rq[c] = 1'b1;
                end
            end
            idle = ($urandom_range(0, 3) != 0);
            step(rq, idle, rr, maxb, ($urandom_range(0, 299) != 0));
        end

        repeat (4) step(4'b0000, 1'b1, 1'b0, 0, 1'b1);
        @(posedge clk);
        #2;
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
